load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 268 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one access at a time from the execute stage,
// issues a word-aligned memory command with byte-lane mask and replicated
// store data, extracts and extends load data, and aborts misaligned or
// illegal-size accesses without touching memory.
// Optional build macro LSU_TIMEOUT_EN adds a watchdog of TIMEOUT_CYCLES
// cycles while waiting on memory; without it the unit waits indefinitely.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wmask,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_misaligned,
    output logic        rsp_timeout,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CMD   = 2'd1,
        ST_RWAIT = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Half needs an even address, word a multiple of four; size 11 is illegal.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic mis;
        case (size)
            2'b00:   mis = 1'b0;
            2'b01:   mis = off[0];
            2'b10:   mis = (off != 2'b00);
            default: mis = 1'b1;
        endcase
        return mis;
    endfunction

    // Byte-lane write mask; loads never write.
    function automatic logic [3:0] calc_wmask(input logic we, input logic [1:0] size,
                                              input logic [1:0] off);
        logic [3:0] m;
        if (!we) begin
            m = 4'b0000;
        end else begin
            case (size)
                2'b00:   m = 4'b0001 << off;
                2'b01:   m = 4'b0011 << {off[1], 1'b0};
                2'b10:   m = 4'b1111;
                default: m = 4'b0000;
            endcase
        end
        return m;
    endfunction

    // Replicate right-justified store data across every lane it may occupy.
    function automatic logic [31:0] calc_wdata(input logic [1:0] size, input logic [31:0] wd);
        logic [31:0] d;
        case (size)
            2'b00:   d = {4{wd[7:0]}};
            2'b01:   d = {2{wd[15:0]}};
            2'b10:   d = wd;
            default: d = 32'h0000_0000;
        endcase
        return d;
    endfunction

    // Pick the addressed lane out of the read word and extend it.
    function automatic logic [31:0] extract_load(input logic [1:0] size, input logic sgn,
                                                 input logic [1:0] off, input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = rd[{off, 3'b000} +: 8];
        h = rd[{off[1], 4'b0000} +: 16];
        case (size)
            2'b00:   r = {{24{sgn & b[7]}}, b};
            2'b01:   r = {{16{sgn & h[15]}}, h};
            2'b10:   r = rd;
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    state_t      state_q, state_d;
    logic        we_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic [1:0]  off_q;
    logic        mem_valid_q;
    logic        mem_we_q;
    logic [31:0] mem_addr_q;
    logic [3:0]  mem_wmask_q;
    logic [31:0] mem_wdata_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_mis_q, rsp_mis_d;
    logic        rsp_tmo_d;
    logic        busy_q;
    logic        req_ready_q;
    logic        accept_s;
    logic        timeout_s;

    assign accept_s = (state_q == ST_IDLE) && req_valid;

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rsp_tmo_q;

    assign timeout_s = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Watchdog counts every cycle spent in CMD or RWAIT; restarts on accept.
    always_comb begin
        cnt_d = {CNT_W{1'b0}};
        if (((state_q == ST_CMD) || (state_q == ST_RWAIT)) &&
            ((state_d == ST_CMD) || (state_d == ST_RWAIT))) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = {CNT_W{1'b0}};
        end
    end

    // Watchdog counter and timeout flag registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= {CNT_W{1'b0}};
            rsp_tmo_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            rsp_tmo_q <= rsp_tmo_d;
        end
    end

    assign rsp_timeout = rsp_tmo_q;
`else
    logic unused_timeout_cfg_s;

    assign unused_timeout_cfg_s = (TIMEOUT_CYCLES == 32'd0) | rsp_tmo_d;
    assign timeout_s            = 1'b0;
    assign rsp_timeout          = 1'b0;
`endif

    // Next-state logic; response qualifiers and load data are decided on the
    // transition into RESP so that they arrive registered with rsp_valid.
    always_comb begin
        state_d     = state_q;
        rsp_mis_d   = 1'b0;
        rsp_tmo_d   = 1'b0;
        rsp_rdata_d = 32'h0000_0000;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (is_misaligned(req_size, req_addr[1:0])) begin
                        state_d   = ST_RESP;
                        rsp_mis_d = 1'b1;
                    end else begin
                        state_d = ST_CMD;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CMD: begin
                if (mem_ready) begin
                    state_d = we_q ? ST_RESP : ST_RWAIT;
                end else if (timeout_s) begin
                    state_d   = ST_RESP;
                    rsp_tmo_d = 1'b1;
                end else begin
                    state_d = ST_CMD;
                end
            end
            ST_RWAIT: begin
                if (mem_rvalid) begin
                    state_d     = ST_RESP;
                    rsp_rdata_d = extract_load(size_q, signed_q, off_q, mem_rdata);
                end else if (timeout_s) begin
                    state_d   = ST_RESP;
                    rsp_tmo_d = 1'b1;
                end else begin
                    state_d = ST_RWAIT;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, captured request and all registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            we_q        <= 1'b0;
            size_q      <= 2'b00;
            signed_q    <= 1'b0;
            off_q       <= 2'b00;
            mem_valid_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0000_0000;
            mem_wmask_q <= 4'b0000;
            mem_wdata_q <= 32'h0000_0000;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0000_0000;
            rsp_mis_q   <= 1'b0;
            busy_q      <= 1'b0;
            req_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            mem_valid_q <= (state_d == ST_CMD);
            rsp_valid_q <= (state_d == ST_RESP);
            rsp_rdata_q <= rsp_rdata_d;
            rsp_mis_q   <= rsp_mis_d;
            busy_q      <= (state_d != ST_IDLE);
            req_ready_q <= (state_d == ST_IDLE);
            if (accept_s) begin
                we_q        <= req_we;
                size_q      <= req_size;
                signed_q    <= req_signed;
                off_q       <= req_addr[1:0];
                mem_we_q    <= req_we;
                mem_addr_q  <= {req_addr[31:2], 2'b00};
                mem_wmask_q <= calc_wmask(req_we, req_size, req_addr[1:0]);
                mem_wdata_q <= calc_wdata(req_size, req_wdata);
            end else begin
                we_q        <= we_q;
                size_q      <= size_q;
                signed_q    <= signed_q;
                off_q       <= off_q;
                mem_we_q    <= mem_we_q;
                mem_addr_q  <= mem_addr_q;
                mem_wmask_q <= mem_wmask_q;
                mem_wdata_q <= mem_wdata_q;
            end
        end
    end

    assign req_ready      = req_ready_q;
    assign mem_valid      = mem_valid_q;
    assign mem_we         = mem_we_q;
    assign mem_addr       = mem_addr_q;
    assign mem_wmask      = mem_wmask_q;
    assign mem_wdata      = mem_wdata_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_rdata      = rsp_rdata_q;
    assign rsp_misaligned = rsp_mis_q;
    assign busy           = busy_q;

endmodule
